// File: rtl/multi_sample_player_pkg.sv
// Shared definitions for the multi-voice sample player.
//   state_e   : sequencer states (idle / per-channel fetch / drain / mix)
//   clog2     : ceiling log2, 0 for an argument of 0 or 1
//   silence   : offset-binary zero level for a given word width
//   slot_base : first ROM address of a sample slot
package multi_sample_player_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StMix
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned silence(input int unsigned data_bits);
    return 32'd1 << (data_bits - 1);
  endfunction

  function automatic int unsigned slot_base(input int unsigned sel,
                                            input int unsigned sample_bits,
                                            input int unsigned addr_bits);
    return sel << (addr_bits - sample_bits);
  endfunction

endpackage

// File: rtl/multi_sample_player_if.sv
// Bus between the game controller / sample ROM side and the sample player.
//   SELECT, TRIGGER : start request from the game controller
//   ROM_ADDR        : ROM read address driven by the player
//   ROM_DATA        : ROM word, valid one cycle after ROM_ADDR
//   BUSY            : per-channel playing flags
//   DROPPED         : one-cycle pulse when a trigger could not be served
//   AUDIO           : 1-bit sigma-delta output
// master = controller/ROM/board side, slave = player.
interface multi_sample_player_if #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned SAMPLE_BITS  = 3,
  parameter int unsigned ADDR_BITS    = 14,
  parameter int unsigned DATA_BITS    = 8
);
  logic [SAMPLE_BITS-1:0]  SELECT;
  logic                    TRIGGER;
  logic [ADDR_BITS-1:0]    ROM_ADDR;
  logic [DATA_BITS-1:0]    ROM_DATA;
  logic [NUM_CHANNELS-1:0] BUSY;
  logic                    DROPPED;
  logic                    AUDIO;

  modport master (
    output SELECT, TRIGGER, ROM_DATA,
    input  ROM_ADDR, BUSY, DROPPED, AUDIO
  );

  modport slave (
    input  SELECT, TRIGGER, ROM_DATA,
    output ROM_ADDR, BUSY, DROPPED, AUDIO
  );
endinterface

// File: rtl/multi_sample_player_sigma_delta_dac.sv
// First-order sigma-delta modulator.
//   CLK, RESET : clock, synchronous active-high reset
//   mix_i      : offset-binary level to reproduce
//   audio_o    : bitstream whose ones-density is mix_i / 2^DATA_BITS
module multi_sample_player_sigma_delta_dac #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [DATA_BITS-1:0] mix_i,
  output logic                 audio_o
);

  logic [DATA_BITS:0] acc_q, acc_d;
  logic               audio_q;

  // The carry is dropped from the fed-back value and emitted as the output bit.
  always_comb begin
    acc_d = {1'b0, acc_q[DATA_BITS-1:0]} + {1'b0, mix_i};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q   <= '0;
      audio_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      audio_q <= acc_d[DATA_BITS];
    end
  end

  assign audio_o = audio_q;

endmodule

// File: rtl/multi_sample_player.sv
// Multi-voice one-shot sample player with sigma-delta output.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : slave side of multi_sample_player_if (SELECT/TRIGGER in,
//                ROM_ADDR out / ROM_DATA in, BUSY, DROPPED, AUDIO out)
// Every CLK_DIV cycles the channels are read one per cycle from the shared
// ROM, summed, scaled by 1/NUM_CHANNELS and handed to the sigma-delta DAC.
// Build option MULTI_SAMPLE_VOICE_STEAL_EN: when all voices are busy a trigger
// restarts a round-robin chosen voice instead of being dropped.
module multi_sample_player
  import multi_sample_player_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned SAMPLE_BITS  = 3,
  parameter int unsigned ADDR_BITS    = 14,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLK_DIV      = 5000,
  parameter int unsigned END_CODE     = 0
) (
  input logic                  CLK,
  input logic                  RESET,
  multi_sample_player_if.slave bus
);

  localparam int unsigned ShiftBits = clog2(NUM_CHANNELS);
  localparam int unsigned IdxW      = (ShiftBits == 0) ? 1 : ShiftBits;
  localparam int unsigned AccW      = DATA_BITS + ShiftBits;
  localparam int unsigned SlotBits  = ADDR_BITS - SAMPLE_BITS;
  localparam int unsigned CntW      = clog2(CLK_DIV);

  localparam logic [DATA_BITS-1:0] Silence = DATA_BITS'(silence(DATA_BITS));
  localparam logic [DATA_BITS-1:0] EndWord = DATA_BITS'(END_CODE);
  localparam logic [IdxW-1:0]      LastIdx = IdxW'(NUM_CHANNELS - 1);
  localparam logic [CntW-1:0]      CntMax  = CntW'(CLK_DIV - 1);

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    tick;
  logic [IdxW-1:0]         k_q, k_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [IdxW-1:0]         pend_k_q, pend_k_d;
  logic [NUM_CHANNELS-1:0] busy_q, busy_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic [ADDR_BITS-1:0]    ptr_q [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    ptr_d [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    rom_addr_q, rom_addr_d;
  logic signed [AccW-1:0]  sum_q, sum_d;
  logic [DATA_BITS-1:0]    mix_q, mix_d;
  logic                    dropped_q, dropped_d;

  logic                    free_found;
  logic [IdxW-1:0]         free_idx;
  logic                    alloc_en;
  logic [IdxW-1:0]         alloc_idx;

  logic                        word_take;
  logic                        word_end;
  logic                        slot_last;
  logic signed [DATA_BITS-1:0] word_val;
  logic signed [AccW-1:0]      word_ext;

  // Sample-rate tick: fires on the edge where the counter wraps to 0.
  assign tick  = (cnt_q == CntMax);
  assign cnt_d = tick ? '0 : cnt_q + CntW'(1);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (tick) state_d = StFetch;
      StFetch: if (k_q == LastIdx) state_d = StDrain;
      StDrain: state_d = StMix;
      StMix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------- Trigger allocation ----------------
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

`ifdef MULTI_SAMPLE_VOICE_STEAL_EN
  logic [IdxW-1:0] steal_q, steal_d;

  always_comb begin
    alloc_en  = bus.TRIGGER;
    alloc_idx = free_found ? free_idx : steal_q;
    dropped_d = 1'b0;
    steal_d   = steal_q;
    if (bus.TRIGGER && !free_found) begin
      steal_d = (steal_q == LastIdx) ? '0 : steal_q + IdxW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) steal_q <= '0;
    else       steal_q <= steal_d;
  end
`else
  always_comb begin
    alloc_en  = bus.TRIGGER && free_found;
    alloc_idx = free_idx;
    dropped_d = bus.TRIGGER && !free_found;
  end
`endif

  // ---------------- ROM word decode ----------------
  // A word is in flight the cycle after each FETCH; only snapshotted channels count.
  assign word_take = pend_vld_q && mask_q[pend_k_q];
  assign word_end  = (bus.ROM_DATA == EndWord);
  assign slot_last = &ptr_q[pend_k_q][SlotBits-1:0];
  // Flipping the MSB turns offset-binary into two's complement.
  assign word_val  = {~bus.ROM_DATA[DATA_BITS-1], bus.ROM_DATA[DATA_BITS-2:0]};
  assign word_ext  = AccW'(word_val);

  // ---------------- FSM outputs / datapath next state ----------------
  always_comb begin
    k_d        = k_q;
    pend_vld_d = 1'b0;
    pend_k_d   = k_q;
    rom_addr_d = rom_addr_q;
    mask_d     = mask_q;
    sum_d      = sum_q;
    mix_d      = mix_q;
    busy_d     = busy_q;
    ptr_d      = ptr_q;

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          mask_d     = busy_q;
          k_d        = '0;
          sum_d      = '0;
          rom_addr_d = ptr_q[0];
        end
      end
      StFetch: begin
        pend_vld_d = 1'b1;
        pend_k_d   = k_q;
        if (k_q != LastIdx) begin
          k_d        = k_q + IdxW'(1);
          rom_addr_d = ptr_q[k_q + IdxW'(1)];
        end
      end
      StMix: begin
        // Arithmetic shift by log2(N) taken as a slice, MSB flipped back to offset-binary.
        mix_d = {~sum_q[AccW-1], sum_q[AccW-2:ShiftBits]};
      end
      default: ;
    endcase

    if (word_take) begin
      if (word_end) begin
        busy_d[pend_k_q] = 1'b0;
      end else begin
        sum_d = sum_q + word_ext;
        // The last word of a slot still plays; the pointer never crosses into the next slot.
        if (slot_last) busy_d[pend_k_q] = 1'b0;
        else           ptr_d[pend_k_q] = ptr_q[pend_k_q] + ADDR_BITS'(1);
      end
    end

    // A (re)started voice is kept out of the current tick's mix.
    if (alloc_en) begin
      ptr_d[alloc_idx]  = ADDR_BITS'(slot_base(32'(bus.SELECT), SAMPLE_BITS, ADDR_BITS));
      busy_d[alloc_idx] = 1'b1;
      mask_d[alloc_idx] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q      <= '0;
      k_q        <= '0;
      pend_vld_q <= 1'b0;
      pend_k_q   <= '0;
      busy_q     <= '0;
      mask_q     <= '0;
      rom_addr_q <= '0;
      sum_q      <= '0;
      mix_q      <= Silence;
      dropped_q  <= 1'b0;
      for (int i = 0; i < int'(NUM_CHANNELS); i++) ptr_q[i] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      pend_vld_q <= pend_vld_d;
      pend_k_q   <= pend_k_d;
      busy_q     <= busy_d;
      mask_q     <= mask_d;
      rom_addr_q <= rom_addr_d;
      sum_q      <= sum_d;
      mix_q      <= mix_d;
      dropped_q  <= dropped_d;
      for (int i = 0; i < int'(NUM_CHANNELS); i++) ptr_q[i] <= ptr_d[i];
    end
  end

  multi_sample_player_sigma_delta_dac #(
    .DATA_BITS(DATA_BITS)
  ) u_sigma_delta_dac (
    .CLK    (CLK),
    .RESET  (RESET),
    .mix_i  (mix_q),
    .audio_o(bus.AUDIO)
  );

  assign bus.ROM_ADDR = rom_addr_q;
  assign bus.BUSY     = busy_q;
  assign bus.DROPPED  = dropped_q;

endmodule
